issue_scoreboard: RTL

- Single-issue, in-order dispatch controller between instruction decode and the execution pipes (ALU, MUL, DIV, LSU).
- Holds one decoded instruction and tracks a per-register pending-write scoreboard.
- Stalls on RAW/WAW hazards, busy pipes and fence drains, then dispatches to exactly one pipe with a registered payload.
- Flushed by WB-stage branch redirect.

---
 rtl/issue_scoreboard_if.sv | 47 ++++
 rtl/issue_scoreboard.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/issue_scoreboard_if.sv
// rtl/issue_scoreboard_if.sv - decode/pipe/writeback signal bundle for issue_scoreboard
//
// Purpose: groups every non-clock signal of the issue scoreboard.
// Modports:
//   master - environment side: drives decode, flush, pipe_ready and release inputs,
//            observes in_ready, the registered issue payload, sb_empty, stall_count.
//   slave  - scoreboard side (opposite directions).
interface issue_scoreboard_if #(
    parameter int REG_WIDTH = 5,
    parameter int NUM_PIPES = 4,
    parameter int NUM_REL   = 2,
    parameter int CNT_WIDTH = 32
);
    logic                         flush;
    logic                         in_valid;
    logic                         in_ready;
    logic [REG_WIDTH-1:0]         in_a1;
    logic [REG_WIDTH-1:0]         in_a2;
    logic [REG_WIDTH-1:0]         in_rd;
    logic                         in_register_write;
    logic [NUM_PIPES-1:0]         in_exe_pipe;
    logic                         in_drain;
    logic [NUM_PIPES-1:0]         pipe_ready;
    logic [NUM_PIPES-1:0]         issue_valid;
    logic [REG_WIDTH-1:0]         issue_a1;
    logic [REG_WIDTH-1:0]         issue_a2;
    logic [REG_WIDTH-1:0]         issue_rd;
    logic                         issue_register_write;
    logic [NUM_REL-1:0]           rel_valid;
    logic [NUM_REL*REG_WIDTH-1:0] rel_rd;
    logic                         sb_empty;
    logic [CNT_WIDTH-1:0]         stall_count;

    modport master (
        output flush, in_valid, in_a1, in_a2, in_rd, in_register_write, in_exe_pipe,
               in_drain, pipe_ready, rel_valid, rel_rd,
        input  in_ready, issue_valid, issue_a1, issue_a2, issue_rd, issue_register_write,
               sb_empty, stall_count
    );

    modport slave (
        input  flush, in_valid, in_a1, in_a2, in_rd, in_register_write, in_exe_pipe,
               in_drain, pipe_ready, rel_valid, rel_rd,
        output in_ready, issue_valid, issue_a1, issue_a2, issue_rd, issue_register_write,
               sb_empty, stall_count
    );
endinterface

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - single-issue in-order dispatch with register scoreboard
//
// Purpose: holds one decoded instruction, stalls it on RAW/WAW hazards, busy target
// pipe or fence drain, then dispatches it to exactly one execution pipe with a
// registered payload. Pending writes are tracked per register and cleared by the
// writeback release ports.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - issue_scoreboard_if.slave: decode handshake (in_*), flush, pipe_ready,
//          registered issue payload (issue_*), release ports (rel_*), sb_empty,
//          saturating stall_count.
module issue_scoreboard #(
    parameter int NUM_REGS  = 32,
    parameter int REG_WIDTH = 5,
    parameter int NUM_PIPES = 4,
    parameter int NUM_REL   = 2,
    parameter int CNT_WIDTH = 32
) (
    input logic              clk,
    input logic              rst,
    issue_scoreboard_if.slave bus
);
    logic                 hold_valid_q, hold_valid_d;
    logic [REG_WIDTH-1:0] hold_a1_q, hold_a1_d;
    logic [REG_WIDTH-1:0] hold_a2_q, hold_a2_d;
    logic [REG_WIDTH-1:0] hold_rd_q, hold_rd_d;
    logic                 hold_wr_q, hold_wr_d;
    logic [NUM_PIPES-1:0] hold_pipe_q, hold_pipe_d;
    logic                 hold_drain_q, hold_drain_d;

    logic [NUM_REGS-1:0]  pending_q, pending_d;

    logic [NUM_PIPES-1:0] issue_valid_q, issue_valid_d;
    logic [REG_WIDTH-1:0] issue_a1_q, issue_a1_d;
    logic [REG_WIDTH-1:0] issue_a2_q, issue_a2_d;
    logic [REG_WIDTH-1:0] issue_rd_q, issue_rd_d;
    logic                 issue_wr_q, issue_wr_d;

    logic [CNT_WIDTH-1:0] stall_q, stall_d;

    logic                 wr_eff;
    logic                 hazard;
    logic                 drain_ok;
    logic                 fire;
    logic                 null_take;
    logic                 consume;
    logic                 in_ready;
    logic                 capture;
    logic                 stall_inc;
    logic                 rel_dup;
    logic                 rel_unpend;
    logic [REG_WIDTH-1:0] rel_idx [NUM_REL];

    always_comb begin
        for (int k = 0; k < NUM_REL; k++) begin
            rel_idx[k] = bus.rel_rd[k*REG_WIDTH +: REG_WIDTH];
        end
    end

    always_comb begin
        // Writes to x0 never occupy the scoreboard.
        wr_eff    = hold_wr_q & (hold_rd_q != '0);
        hazard    = pending_q[hold_a1_q] | pending_q[hold_a2_q] | (wr_eff & pending_q[hold_rd_q]);
        drain_ok  = ~hold_drain_q | (pending_q == '0);
        fire      = hold_valid_q & ~bus.flush & ~hazard & (|(hold_pipe_q & bus.pipe_ready)) & drain_ok;
        // An instruction targeting no pipe is dropped without touching issue or scoreboard.
        null_take = hold_valid_q & ~bus.flush & (hold_pipe_q == '0);
        consume   = fire | null_take;
        in_ready  = ~bus.flush & (~hold_valid_q | consume);
        capture   = bus.in_valid & in_ready;
        stall_inc = hold_valid_q & ~consume & ~bus.flush;

        hold_valid_d = hold_valid_q;
        hold_a1_d    = hold_a1_q;
        hold_a2_d    = hold_a2_q;
        hold_rd_d    = hold_rd_q;
        hold_wr_d    = hold_wr_q;
        hold_pipe_d  = hold_pipe_q;
        hold_drain_d = hold_drain_q;
        if (bus.flush) begin
            hold_valid_d = 1'b0;
        end else if (capture) begin
            hold_valid_d = 1'b1;
            hold_a1_d    = bus.in_a1;
            hold_a2_d    = bus.in_a2;
            hold_rd_d    = bus.in_rd;
            hold_wr_d    = bus.in_register_write;
            hold_pipe_d  = bus.in_exe_pipe;
            hold_drain_d = bus.in_drain;
        end else if (consume) begin
            hold_valid_d = 1'b0;
        end

        // Clear and set never collide on one bit: fire requires rd not pending,
        // and only pending registers may be released.
        pending_d = pending_q;
        for (int k = 0; k < NUM_REL; k++) begin
            if (bus.rel_valid[k]) begin
                pending_d[rel_idx[k]] = 1'b0;
            end
        end
        if (fire & wr_eff) begin
            pending_d[hold_rd_q] = 1'b1;
        end
        pending_d[0] = 1'b0;

        issue_valid_d = '0;
        issue_a1_d    = issue_a1_q;
        issue_a2_d    = issue_a2_q;
        issue_rd_d    = issue_rd_q;
        issue_wr_d    = issue_wr_q;
        if (fire) begin
            issue_valid_d = hold_pipe_q;
            issue_a1_d    = hold_a1_q;
            issue_a2_d    = hold_a2_q;
            issue_rd_d    = hold_rd_q;
            issue_wr_d    = hold_wr_q;
        end

        stall_d = stall_q;
        if (stall_inc && (stall_q != '1)) begin
            stall_d = stall_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_q  <= 1'b0;
            hold_a1_q     <= '0;
            hold_a2_q     <= '0;
            hold_rd_q     <= '0;
            hold_wr_q     <= 1'b0;
            hold_pipe_q   <= '0;
            hold_drain_q  <= 1'b0;
            pending_q     <= '0;
            issue_valid_q <= '0;
            issue_a1_q    <= '0;
            issue_a2_q    <= '0;
            issue_rd_q    <= '0;
            issue_wr_q    <= 1'b0;
            stall_q       <= '0;
        end else begin
            hold_valid_q  <= hold_valid_d;
            hold_a1_q     <= hold_a1_d;
            hold_a2_q     <= hold_a2_d;
            hold_rd_q     <= hold_rd_d;
            hold_wr_q     <= hold_wr_d;
            hold_pipe_q   <= hold_pipe_d;
            hold_drain_q  <= hold_drain_d;
            pending_q     <= pending_d;
            issue_valid_q <= issue_valid_d;
            issue_a1_q    <= issue_a1_d;
            issue_a2_q    <= issue_a2_d;
            issue_rd_q    <= issue_rd_d;
            issue_wr_q    <= issue_wr_d;
            stall_q       <= stall_d;
        end
    end

    assign bus.in_ready             = in_ready;
    assign bus.issue_valid          = issue_valid_q;
    assign bus.issue_a1             = issue_a1_q;
    assign bus.issue_a2             = issue_a2_q;
    assign bus.issue_rd             = issue_rd_q;
    assign bus.issue_register_write = issue_wr_q;
    assign bus.sb_empty             = (pending_q == '0);
    assign bus.stall_count          = stall_q;

    // Release protocol checks: no duplicate register across ports, no release of a
    // register that is not pending. Releases of x0 are ignored entirely.
    always_comb begin
        rel_dup    = 1'b0;
        rel_unpend = 1'b0;
        for (int k = 0; k < NUM_REL; k++) begin
            if (bus.rel_valid[k] && (rel_idx[k] != '0)) begin
                if (!pending_q[rel_idx[k]]) begin
                    rel_unpend = 1'b1;
                end
                for (int j = k + 1; j < NUM_REL; j++) begin
                    if (bus.rel_valid[j] && (rel_idx[j] == rel_idx[k])) begin
                        rel_dup = 1'b1;
                    end
                end
            end
        end
    end

    a_rel_dup: assert property (@(posedge clk) disable iff (rst) !rel_dup);
    a_rel_unpend: assert property (@(posedge clk) disable iff (rst) !rel_unpend);

endmodule
